// File: rtl/icm_get_lookup_responder_pkg.sv
// Shared constants for the ICM get-lookup responder: head field layout, cache geometry and
// FSM state encodings.
package icm_get_lookup_responder_pkg;

    localparam int unsigned COUNT_MAX_LOG       = 2;
    localparam int unsigned REQ_TAG_WIDTH       = 5;
    localparam int unsigned PHYSICAL_ADDR_WIDTH = 12;
    localparam int unsigned ICM_ADDR_WIDTH      = 64;
    localparam int unsigned CACHE_ADDR_WIDTH    = 21;
    localparam int unsigned CACHE_OFFSET_WIDTH  = 5;
    localparam int unsigned CACHE_SET_NUM_LOG   = 10;
    localparam int unsigned CACHE_TAG_WIDTH     =
        CACHE_ADDR_WIDTH - CACHE_OFFSET_WIDTH - CACHE_SET_NUM_LOG;
    localparam int unsigned CACHE_ENTRY_WIDTH   = 256;
    localparam int unsigned HEAD_WIDTH          =
        COUNT_MAX_LOG * 2 + REQ_TAG_WIDTH + PHYSICAL_ADDR_WIDTH + ICM_ADDR_WIDTH;

    // Head layout from LSB: icm_addr, phy_addr, req_tag, count_index, count_total.
    localparam int unsigned ICM_ADDR_LSB    = 0;
    localparam int unsigned PHY_ADDR_LSB    = ICM_ADDR_LSB + ICM_ADDR_WIDTH;
    localparam int unsigned REQ_TAG_LSB     = PHY_ADDR_LSB + PHYSICAL_ADDR_WIDTH;
    localparam int unsigned COUNT_INDEX_LSB = REQ_TAG_LSB + REQ_TAG_WIDTH;
    localparam int unsigned COUNT_TOTAL_LSB = COUNT_INDEX_LSB + COUNT_MAX_LOG;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StTagRd    = 3'd1;
    localparam logic [2:0] StTagCmp   = 3'd2;
    localparam logic [2:0] StDataWait = 3'd3;
    localparam logic [2:0] StRspHit   = 3'd4;
    localparam logic [2:0] StRspMiss  = 3'd5;

endpackage

// File: rtl/icm_get_lookup_responder_if.sv
// Request, tag/data SRAM read and hit/miss response signals of the ICM get-lookup responder.
interface icm_get_lookup_responder_if;
    import icm_get_lookup_responder_pkg::*;

    logic                         cache_get_req_valid;
    logic [HEAD_WIDTH-1:0]        cache_get_req_head;
    logic                         cache_get_req_ready;

    logic                         tag_rd_en;
    logic [CACHE_SET_NUM_LOG-1:0] tag_rd_addr;
    logic [CACHE_TAG_WIDTH:0]     tag_rd_data;

    logic                         data_rd_en;
    logic [CACHE_SET_NUM_LOG-1:0] data_rd_addr;
    logic [CACHE_ENTRY_WIDTH-1:0] data_rd_data;

    logic                         hit_rsp_valid;
    logic [HEAD_WIDTH-1:0]        hit_rsp_head;
    logic [CACHE_ENTRY_WIDTH-1:0] hit_rsp_data;
    logic                         hit_rsp_ready;

    logic                         miss_req_valid;
    logic [HEAD_WIDTH-1:0]        miss_req_head;
    logic                         miss_req_ready;

    modport slave (
        input  cache_get_req_valid, cache_get_req_head, tag_rd_data, data_rd_data,
               hit_rsp_ready, miss_req_ready,
        output cache_get_req_ready, tag_rd_en, tag_rd_addr, data_rd_en, data_rd_addr,
               hit_rsp_valid, hit_rsp_head, hit_rsp_data, miss_req_valid, miss_req_head
    );

    modport master (
        output cache_get_req_valid, cache_get_req_head, tag_rd_data, data_rd_data,
               hit_rsp_ready, miss_req_ready,
        input  cache_get_req_ready, tag_rd_en, tag_rd_addr, data_rd_en, data_rd_addr,
               hit_rsp_valid, hit_rsp_head, hit_rsp_data, miss_req_valid, miss_req_head
    );

endinterface

// File: rtl/icm_lookup_addr_decode.sv
// Splits the cache line address (icm_addr above the slot offset) into set index and tag.
module icm_lookup_addr_decode
    import icm_get_lookup_responder_pkg::*;
(
    input  logic [CACHE_TAG_WIDTH+CACHE_SET_NUM_LOG-1:0] line_addr_i,
    output logic [CACHE_SET_NUM_LOG-1:0]                 set_o,
    output logic [CACHE_TAG_WIDTH-1:0]                   tag_o
);

    assign set_o = line_addr_i[CACHE_SET_NUM_LOG-1:0];
    assign tag_o = line_addr_i[CACHE_SET_NUM_LOG +: CACHE_TAG_WIDTH];

endmodule

// File: rtl/icm_get_lookup_responder.sv
// ICM cache get-request responder: direct-mapped tag lookup, hit data read or miss forward.
// Optional hit/miss statistics counters are built when ICM_LOOKUP_STAT_EN is defined.
module icm_get_lookup_responder
    import icm_get_lookup_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
`ifdef ICM_LOOKUP_STAT_EN
    output logic [31:0] stat_hit_cnt,
    output logic [31:0] stat_miss_cnt,
`endif
    icm_get_lookup_responder_if.slave bus
);

    logic [2:0]                   state_q, state_d;
    logic [HEAD_WIDTH-1:0]        head_q, head_d;
    logic [CACHE_ENTRY_WIDTH-1:0] data_q, data_d;
    logic [CACHE_SET_NUM_LOG-1:0] set;
    logic [CACHE_TAG_WIDTH-1:0]   tag;
    logic                         hit;

    icm_lookup_addr_decode u_addr_decode (
        .line_addr_i (head_q[ICM_ADDR_LSB + CACHE_OFFSET_WIDTH +:
                             CACHE_TAG_WIDTH + CACHE_SET_NUM_LOG]),
        .set_o       (set),
        .tag_o       (tag)
    );

    assign hit = bus.tag_rd_data[CACHE_TAG_WIDTH] &&
                 (bus.tag_rd_data[CACHE_TAG_WIDTH-1:0] == tag);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                if (bus.cache_get_req_valid) begin
                    head_d  = bus.cache_get_req_head;
                    state_d = StTagRd;
                end
            end
            StTagRd:    state_d = StTagCmp;
            StTagCmp:   state_d = hit ? StDataWait : StRspMiss;
            StDataWait: begin
                data_d  = bus.data_rd_data;
                state_d = StRspHit;
            end
            StRspHit:   if (bus.hit_rsp_ready) state_d = StIdle;
            StRspMiss:  if (bus.miss_req_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            head_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            data_q  <= data_d;
        end
    end

    // Gated by rst so ready reads 0 while reset is held, even though the state is already idle.
    assign bus.cache_get_req_ready = rst && (state_q == StIdle);

    assign bus.tag_rd_en      = (state_q == StTagRd);
    assign bus.tag_rd_addr    = bus.tag_rd_en ? set : '0;
    assign bus.data_rd_en     = (state_q == StTagCmp) && hit;
    assign bus.data_rd_addr   = bus.data_rd_en ? set : '0;

    assign bus.hit_rsp_valid  = (state_q == StRspHit);
    assign bus.hit_rsp_head   = head_q;
    assign bus.hit_rsp_data   = data_q;
    assign bus.miss_req_valid = (state_q == StRspMiss);
    assign bus.miss_req_head  = head_q;

`ifdef ICM_LOOKUP_STAT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (bus.hit_rsp_valid && bus.hit_rsp_ready && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (bus.miss_req_valid && bus.miss_req_ready && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign stat_hit_cnt  = hit_cnt_q;
    assign stat_miss_cnt = miss_cnt_q;
`endif

endmodule
